adder3: RTL and testbench
=========================

Name: adder3

Overview:
- Registered 3-bit binary adder with carry-in and carry-out, one result per clock.
- Leaf arithmetic block used as a partition of a wider adder datapath.
- Computes {cout, sum} = a + b + cin.
- Output is captured in a single pipeline register stage with a valid qualifier.

Parameters:
- WIDTH, 3, operand width in bits. Must be >= 1. All behaviour below is stated for the default. For other values, sum width = WIDTH and cout is the carry out of bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a, b, cin in the current cycle.
- a  input  WIDTH  operand A, unsigned. Bit 2 is the MSB; corresponds to packed input vector bits [6:4].
- b  input  WIDTH  operand B, unsigned. Corresponds to packed input bits [3:1].
- cin  input  1  carry-in. Corresponds to packed input bit [0].
- out_valid  output  1  high for one cycle when sum/cout hold a new result.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH. Packed output bits [2:0].
- cout  output  1  registered carry out, i.e. bit WIDTH of a + b + cin. Packed output bit [3].

Behaviour:
- Arithmetic:
  - Full-width unsigned addition; total range 0..15 for WIDTH=3.
  - {cout, sum} = a + b + cin exactly. No saturation, no approximation, no truncation beyond WIDTH+1 bits.
  - Implementation: ripple-carry chain of per-bit full adders.
    - s_i = a_i ^ b_i ^ c_i
    - c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i))
    - c_0 = cin
    - cout = c_WIDTH
- Timing:
  - Inputs are sampled on the rising edge of clk when in_valid=1.
  - Result appears on sum/cout with out_valid=1 after that same edge, giving 1-cycle latency.
  - Throughput is one operation per cycle; back-to-back in_valid is fully supported.
- Hold rules:
  - When in_valid=0 at an edge: out_valid drops to 0 and sum/cout hold their previous values.
  - No stall or backpressure exists; a result is presented for exactly one cycle of out_valid per accepted input.
- Reset:
  - When rst=1 at a rising edge: out_valid=0, sum=0, cout=0.
  - Reset has priority over in_valid in the same cycle; that input is discarded.
  - Reset asserted mid-stream kills any result that would have appeared the following cycle.
  - First valid output after reset release requires in_valid=1 on a cycle with rst=0.
- X/unknown inputs while in_valid=0 must not affect the outputs.
- No internal state other than the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=7, b=7, cin=1 -> out_valid=0, sum=000, cout=0 throughout. On the cycle after rst falls, out_valid=1, sum=111, cout=1.
- Corner values:
  - a=0, b=0, cin=0 -> {cout,sum}=0000.
  - a=7, b=7, cin=1 -> 1111.
  - a=7, b=0, cin=1 -> 1000 (full carry ripple).
  - a=5, b=3, cin=0 -> 1000.
  - a=2, b=1, cin=1 -> 0100.
- Exhaustive: drive all 128 packed 7-bit vectors 0000000..1111111 back-to-back with in_valid=1. Each result must equal a+b+cin, one cycle later, with out_valid continuously high.
  - Vector 0000001 -> 0001.
  - Vector 0010010 -> 0010.
  - Vector 1111111 -> 1111.
- Bubble: a=3, b=4, cin=1, in_valid=1, then in_valid=0 for 2 cycles with a=b=0 -> out_valid pulses 1,0,0. sum/cout stay at 1000 during the bubble.
- Reset mid-stream: apply a=1, b=1, cin=0 with in_valid=1 and rst=1 in the same cycle -> next cycle out_valid=0, sum=000, cout=0.

Source files
------------

// File: rtl/adder3.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin, captured
// one cycle after an accepted input and flagged by out_valid.
module adder3 #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_next;

   // Full-adder chain: carry[0] is cin and carry[WIDTH] becomes cout.
   always_comb begin
      carry    = '0;
      sum_next = '0;
      carry[0] = cin;
      for (int i = 0; i < WIDTH; i++) begin
         sum_next[i]  = a[i] ^ b[i] ^ carry[i];
         carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   // Reset wins over in_valid; idle cycles keep the last result and only drop out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= sum_next;
            cout <= carry[WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_adder3.sv
// Self-checking bench for adder3: expected results are queued when a
// transaction is driven and popped when the registered output is due.
module tb_adder3;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [2:0] a;
   logic [2:0] b;
   logic       cin;
   logic       out_valid;
   logic [2:0] sum;
   logic       cout;

   logic [3:0] sb_queue[$];
   logic [3:0] held_result;
   logic       exp_valid;
   int         compared;
   int         mismatched;

   adder3 #(.WIDTH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare registered outputs with the model state after the edge.
   task automatic checkOutput(input string tag);
      compared++;
      assert (out_valid === exp_valid) else begin
         mismatched++;
         $error("[TB] FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, exp_valid);
      end
      compared++;
      assert ({cout, sum} === held_result) else begin
         mismatched++;
         $error("[TB] FAIL %s {cout,sum} observed=%04b expected=%04b", tag, {cout, sum}, held_result);
      end
   endtask

   // Drive one cycle of inputs, update the scoreboard and check after the edge.
   task automatic applyStimulus(input logic r, input logic v, input logic [2:0] aa,
                                input logic [2:0] bb, input logic cc, input string tag);
      rst      = r;
      in_valid = v;
      a        = aa;
      b        = bb;
      cin      = cc;
      if (r) begin
         sb_queue.delete();
         held_result = 4'b0000;
         exp_valid   = 1'b0;
      end else begin
         exp_valid = v;
         if (v) sb_queue.push_back({1'b0, aa} + {1'b0, bb} + {3'b000, cc});
      end
      @(posedge clk);
      #1;
      if (exp_valid) begin
         if (sb_queue.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
         end else begin
            held_result = sb_queue.pop_front();
         end
      end
      checkOutput(tag);
   endtask

   initial begin
      logic [6:0] vec;
      compared    = 0;
      mismatched  = 0;
      held_result = 4'b0000;
      exp_valid   = 1'b0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      a           = 3'd0;
      b           = 3'd0;
      cin         = 1'b0;
      @(negedge clk);

      $display("[TB] reset with valid inputs present");
      applyStimulus(1'b1, 1'b1, 3'd7, 3'd7, 1'b1, "reset_0");
      applyStimulus(1'b1, 1'b1, 3'd7, 3'd7, 1'b1, "reset_1");
      applyStimulus(1'b0, 1'b1, 3'd7, 3'd7, 1'b1, "reset_release");

      $display("[TB] corner values");
      applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 1'b0, "zero");
      applyStimulus(1'b0, 1'b1, 3'd7, 3'd7, 1'b1, "max");
      applyStimulus(1'b0, 1'b1, 3'd7, 3'd0, 1'b1, "ripple");
      applyStimulus(1'b0, 1'b1, 3'd5, 3'd3, 1'b0, "five_three");
      applyStimulus(1'b0, 1'b1, 3'd2, 3'd1, 1'b1, "two_one_c");

      $display("[TB] exhaustive back-to-back sweep");
      for (int i = 0; i < 128; i++) begin
         vec = i[6:0];
         applyStimulus(1'b0, 1'b1, vec[6:4], vec[3:1], vec[0], $sformatf("vec_%07b", vec));
      end

      $display("[TB] bubble");
      applyStimulus(1'b0, 1'b1, 3'd3, 3'd4, 1'b1, "bubble_in");
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, "bubble_0");
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, "bubble_1");
      applyStimulus(1'b0, 1'b0, 3'bxxx, 3'bxxx, 1'bx, "idle_unknown");

      $display("[TB] reset mid-stream");
      applyStimulus(1'b0, 1'b1, 3'd6, 3'd5, 1'b1, "pre_kill");
      applyStimulus(1'b1, 1'b1, 3'd1, 3'd1, 1'b0, "kill");
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, "after_kill");
      applyStimulus(1'b0, 1'b1, 3'd4, 3'd4, 1'b0, "restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
